// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit async SRAM between a priority VGA read port and a CPU r/w port
module sram_arbiter #(
  parameter int AW = 18,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int VGA_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_ack,
  output logic [15:0]   vga_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  input  logic [1:0]    cpu_be,
  output logic          cpu_ack,
  output logic [15:0]   cpu_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [15:0]   sram_dq_out,
  output logic          sram_dq_oe,
  input  logic [15:0]   sram_dq_in,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_lb_n,
  output logic          sram_ub_n,
  output logic          busy
);
  localparam int MW = RD_WAIT > WR_WAIT ? RD_WAIT : WR_WAIT;
  localparam int CW = $clog2(MW + 1);
  localparam int SW = $clog2(VGA_BURST_MAX + 1);
  typedef enum logic [1:0] {IDLE, STROBE, RECOVER} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic own_cpu, we, gnt_cpu, gnt_any, wr;
  always_comb begin
    gnt_cpu = cpu_req && (!vga_req || starve == SW'(VGA_BURST_MAX));
    gnt_any = vga_req || cpu_req;
    wr = gnt_cpu && cpu_we;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      starve <= '0;
      own_cpu <= 1'b0;
      we <= 1'b0;
      vga_ack <= 1'b0;
      cpu_ack <= 1'b0;
      vga_rdata <= '0;
      cpu_rdata <= '0;
      sram_addr <= '0;
      sram_dq_out <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
    end else begin
      vga_ack <= 1'b0;
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          starve <= (!cpu_req || gnt_cpu) ? '0 : starve + SW'(1);
          if (gnt_any) begin
            state <= STROBE;
            own_cpu <= gnt_cpu;
            we <= wr;
            cnt <= wr ? CW'(WR_WAIT) : CW'(RD_WAIT);
            sram_addr <= gnt_cpu ? cpu_addr : vga_addr;
            sram_dq_out <= wr ? cpu_wdata : sram_dq_out;
            sram_dq_oe <= wr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= wr;
            sram_we_n <= !wr;
            sram_lb_n <= wr && !cpu_be[0];
            sram_ub_n <= wr && !cpu_be[1];
          end
        end
        STROBE: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= RECOVER;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ce_n <= !we;
            sram_lb_n <= !we || sram_lb_n;
            sram_ub_n <= !we || sram_ub_n;
            cpu_ack <= own_cpu;
            vga_ack <= !own_cpu;
            cpu_rdata <= (!we && own_cpu) ? sram_dq_in : cpu_rdata;
            vga_rdata <= (!we && !own_cpu) ? sram_dq_in : vga_rdata;
          end
        end
        RECOVER: begin
          state <= IDLE;
          sram_ce_n <= 1'b1;
          sram_lb_n <= 1'b1;
          sram_ub_n <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of the SRAM arbiter against a behavioural async SRAM model
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vga_req = 1'b0, cpu_req = 1'b0, vga_req_6 = 1'b0, cpu_req_6 = 1'b0;
  logic cpu_we = 1'b0;
  logic [17:0] vga_addr = '0, cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [1:0] cpu_be = '0;
  logic vga_ack, cpu_ack, dq_oe, ce_n, oe_n, we_n, lb_n, ub_n, busy;
  logic [15:0] vga_rdata, cpu_rdata, dq_out, dq_in;
  logic [17:0] addr;
  logic vga_ack_6, cpu_ack_6, dq_oe_6, ce_n_6, oe_n_6, we_n_6, lb_n_6, ub_n_6, busy_6;
  logic [15:0] vga_rdata_6, cpu_rdata_6, dq_out_6, dq_in_6;
  logic [17:0] addr_6;
  logic [15:0] mem0 [0:(1<<18)-1];
  logic [15:0] mem6 [0:(1<<18)-1];
  logic pl_en = 1'b0, pl_sel = 1'b0;
  logic [17:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  int checks = 0, failures = 0, n = 0;
  logic seq [0:5];
  always #5 clk = ~clk;
  sram_arbiter dut (
    .clk(clk), .reset(reset), .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .vga_rdata(vga_rdata), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .sram_addr(addr), .sram_dq_out(dq_out), .sram_dq_oe(dq_oe), .sram_dq_in(dq_in),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_lb_n(lb_n),
    .sram_ub_n(ub_n), .busy(busy)
  );
  sram_arbiter #(.RD_WAIT(1), .WR_WAIT(3)) d6 (
    .clk(clk), .reset(reset), .vga_req(vga_req_6), .vga_addr(vga_addr), .vga_ack(vga_ack_6),
    .vga_rdata(vga_rdata_6), .cpu_req(cpu_req_6), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ack(cpu_ack_6), .cpu_rdata(cpu_rdata_6),
    .sram_addr(addr_6), .sram_dq_out(dq_out_6), .sram_dq_oe(dq_oe_6), .sram_dq_in(dq_in_6),
    .sram_ce_n(ce_n_6), .sram_oe_n(oe_n_6), .sram_we_n(we_n_6), .sram_lb_n(lb_n_6),
    .sram_ub_n(ub_n_6), .busy(busy_6)
  );
  assign dq_in = mem0[addr];
  assign dq_in_6 = mem6[addr_6];
  always @(posedge clk) begin
    if (pl_en && !pl_sel) mem0[pl_addr] <= pl_data;
    if (pl_en && pl_sel) mem6[pl_addr] <= pl_data;
    if (!ce_n && !we_n && dq_oe && !lb_n) mem0[addr][7:0] <= dq_out[7:0];
    if (!ce_n && !we_n && dq_oe && !ub_n) mem0[addr][15:8] <= dq_out[15:8];
    if (!ce_n_6 && !we_n_6 && dq_oe_6 && !lb_n_6) mem6[addr_6][7:0] <= dq_out_6[7:0];
    if (!ce_n_6 && !we_n_6 && dq_oe_6 && !ub_n_6) mem6[addr_6][15:8] <= dq_out_6[15:8];
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic preload(input logic sel, input logic [17:0] a, input logic [15:0] d);
    pl_sel = sel;
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    preload(1'b0, 18'h00123, 16'hBEEF);
    preload(1'b0, 18'h3FFFF, 16'hABCD);
    preload(1'b0, 18'h00010, 16'h1111);
    preload(1'b0, 18'h00020, 16'h2222);
    preload(1'b1, 18'h00007, 16'h7777);
    preload(1'b1, 18'h00008, 16'h1122);
    chk("rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    chk("rst_misc", {27'd0, dq_oe, vga_ack, cpu_ack, busy, busy_6}, 32'h0);
    chk("rst_rdata", {vga_rdata, cpu_rdata}, 32'h0);
    chk("rst_addr_dq", {addr[15:0], dq_out}, 32'h0);
    reset = 1'b0;
    tick();
    vga_req = 1'b1;
    vga_addr = 18'h00123;
    tick();
    chk("t1_c1_strb", {28'd0, ce_n, oe_n, we_n, dq_oe}, 32'h2);
    chk("t1_c1_addr", {14'd0, addr}, 32'h00123);
    tick();
    chk("t1_c2_oe", {31'd0, oe_n}, 32'h0);
    tick();
    chk("t1_c3_ack", {30'd0, vga_ack, cpu_ack}, 32'h2);
    chk("t1_c3_data", {16'd0, vga_rdata}, 32'hBEEF);
    chk("t1_c3_oe", {30'd0, oe_n, ce_n}, 32'h3);
    vga_req = 1'b0;
    tick();
    chk("t1_c4_idle", {30'd0, busy, vga_ack}, 32'h0);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 18'h3FFFF;
    cpu_wdata = 16'h1234;
    cpu_be = 2'b01;
    tick();
    chk("t2_c1_strb", {26'd0, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, 32'h13);
    chk("t2_c1_bus", {addr[15:0], dq_out}, 32'hFFFF1234);
    tick();
    chk("t2_c2_we", {30'd0, we_n, dq_oe}, 32'h1);
    tick();
    chk("t2_c3_hold", {28'd0, cpu_ack, we_n, dq_oe, ce_n}, 32'hE);
    cpu_req = 1'b0;
    tick();
    chk("t2_c4_rel", {29'd0, cpu_ack, dq_oe, ce_n}, 32'h1);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    tick();
    tick();
    tick();
    chk("t2_rb_ack", {31'd0, cpu_ack}, 32'h1);
    chk("t2_rb_data", {16'd0, cpu_rdata}, 32'hAB34);
    cpu_req = 1'b0;
    tick();
    vga_req = 1'b1;
    vga_addr = 18'h00010;
    cpu_req = 1'b1;
    cpu_addr = 18'h00020;
    tick();
    tick();
    tick();
    chk("t3_c3_acks", {30'd0, vga_ack, cpu_ack}, 32'h2);
    chk("t3_c3_data", {16'd0, vga_rdata}, 32'h1111);
    vga_req = 1'b0;
    tick();
    chk("t3_c4_idle", {31'd0, busy}, 32'h0);
    tick();
    chk("t3_c5_cpu", {15'd0, oe_n, addr[15:0]}, 32'h0020);
    tick();
    chk("t3_c6_noack", {30'd0, vga_ack, cpu_ack}, 32'h0);
    tick();
    chk("t3_c7_acks", {30'd0, vga_ack, cpu_ack}, 32'h1);
    chk("t3_c7_data", {16'd0, cpu_rdata}, 32'h2222);
    cpu_req = 1'b0;
    tick();
    vga_req = 1'b1;
    cpu_req = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      tick();
      chk("t4_excl", {31'd0, vga_ack & cpu_ack}, 32'h0);
      if (vga_ack) begin
        seq[n] = 1'b0;
        n++;
      end
      if (cpu_ack) begin
        seq[n] = 1'b1;
        n++;
        cpu_req = 1'b0;
      end
      if (n == 6) vga_req = 1'b0;
    end
    vga_req = 1'b0;
    cpu_req = 1'b0;
    chk("t4_count", n, 32'd6);
    chk("t4_order", {26'd0, seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]}, 32'b000010);
    tick();
    chk("t4_idle", {31'd0, busy}, 32'h0);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 18'h00040;
    cpu_wdata = 16'h5555;
    cpu_be = 2'b11;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t5_strobes", {26'd0, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, 32'h3E);
    chk("t5_noack", {29'd0, cpu_ack, vga_ack, busy}, 32'h0);
    reset = 1'b0;
    cpu_req = 1'b0;
    tick();
    chk("t5_c4_noack", {31'd0, cpu_ack}, 32'h0);
    cpu_req = 1'b1;
    cpu_addr = 18'h00041;
    cpu_wdata = 16'h6666;
    tick();
    tick();
    tick();
    chk("t5_fresh_ack", {31'd0, cpu_ack}, 32'h1);
    cpu_req = 1'b0;
    tick();
    chk("t5_fresh_mem", {16'd0, mem0[18'h00041]}, 32'h6666);
    vga_req_6 = 1'b1;
    vga_addr = 18'h00007;
    tick();
    chk("t6_rd_c1", {30'd0, oe_n_6, vga_ack_6}, 32'h0);
    tick();
    chk("t6_rd_ack", {31'd0, vga_ack_6}, 32'h1);
    chk("t6_rd_data", {16'd0, vga_rdata_6}, 32'h7777);
    vga_req_6 = 1'b0;
    tick();
    chk("t6_rd_idle", {31'd0, busy_6}, 32'h0);
    cpu_req_6 = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 18'h00008;
    cpu_wdata = 16'h9ABC;
    cpu_be = 2'b10;
    tick();
    tick();
    tick();
    chk("t6_wr_c3", {29'd0, we_n_6, lb_n_6, cpu_ack_6}, 32'h2);
    tick();
    chk("t6_wr_ack", {30'd0, cpu_ack_6, we_n_6}, 32'h3);
    cpu_req_6 = 1'b0;
    tick();
    chk("t6_wr_mem", {16'd0, mem6[18'h00008]}, 32'h9A22);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
